// File: rtl/uart_sram_tx_interface_if.sv
// SRAM read port used by the UART transmit path.
interface uart_sram_tx_interface_if;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n;

   // Transmitter side: drives the address, receives read data
   modport master (
      output SRAM_address,
      output SRAM_we_n,
      input  SRAM_read_data
   );

   // SRAM controller side
   modport slave (
      input  SRAM_address,
      input  SRAM_we_n,
      output SRAM_read_data
   );
endinterface

// File: rtl/uart_sram_tx_interface.sv
// uart_sram_tx_interface: streams a block of 16-bit SRAM words out of the
// UART transmit pin as 8N1 frames, high byte first, then low byte.
module uart_sram_tx_interface #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                            CLOCK_50_I,
   input  logic                            resetn,
   input  logic                            Start,
   input  logic [17:0]                     Start_address,
   input  logic [17:0]                     Word_count,
   uart_sram_tx_interface_if.master        sram,
   output logic                            UART_TX_O,
   output logic                            Busy,
   output logic                            Done
);
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = 4;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(9);

   typedef enum logic [2:0] {
      S_TX_IDLE,
      S_TX_READ,
      S_TX_WAIT1,
      S_TX_WAIT2,
      S_TX_SEND_HI,
      S_TX_SEND_LO,
      S_TX_DONE
   } tx_state_t;

   tx_state_t         state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] words;
   logic [ADDR_W-1:0] sram_addr;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [7:0]        lo_byte;   // only the low byte is still needed once the high frame is loaded
   logic [8:0]        shift;     // remaining frame bits after the start bit: {stop, data[7:0]}

   assign sram.SRAM_address = sram_addr;
   assign sram.SRAM_we_n    = 1'b1;

   // Transfer sequencer, baud/bit timing and registered serial output
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state     <= S_TX_IDLE;
         addr      <= '0;
         words     <= '0;
         sram_addr <= '0;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         lo_byte   <= '0;
         shift     <= '1;
         UART_TX_O <= 1'b1;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_TX_IDLE: begin
               UART_TX_O <= 1'b1;
               if (Start) begin
                  addr  <= Start_address;
                  words <= Word_count;
                  Busy  <= 1'b1;
                  state <= (Word_count == '0) ? S_TX_DONE : S_TX_READ;
               end
            end
            S_TX_READ: begin
               sram_addr <= addr;
               state     <= S_TX_WAIT1;
            end
            S_TX_WAIT1: begin
               state <= S_TX_WAIT2;
            end
            S_TX_WAIT2: begin
               lo_byte   <= sram.SRAM_read_data[7:0];
               shift     <= {1'b1, sram.SRAM_read_data[15:8]};
               UART_TX_O <= 1'b0;
               baud_cnt  <= '0;
               bit_cnt   <= '0;
               state     <= S_TX_SEND_HI;
            end
            S_TX_SEND_HI, S_TX_SEND_LO: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (state == S_TX_SEND_HI) begin
                        shift     <= {1'b1, lo_byte};
                        UART_TX_O <= 1'b0;
                        state     <= S_TX_SEND_LO;
                     end else begin
                        UART_TX_O <= 1'b1;
                        words     <= words - ADDR_W'(1);
                        addr      <= addr + ADDR_W'(1);
                        state     <= (words == ADDR_W'(1)) ? S_TX_DONE : S_TX_READ;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + BIT_W'(1);
                     UART_TX_O <= shift[0];
                     shift     <= {1'b1, shift[8:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            S_TX_DONE: begin
               UART_TX_O <= 1'b1;
               Done      <= 1'b1;
               Busy      <= 1'b0;
               state     <= S_TX_IDLE;
            end
            default: begin
               UART_TX_O <= 1'b1;
               state     <= S_TX_IDLE;
            end
         endcase
      end
   end
endmodule
